// File: rtl/read_enable_scheduler.sv
// Round-robin one-hot enable sequencer for readers sharing one sample slot.
// Enables are issued at a divided rate, grouped into bursts separated by gaps.
module read_enable_scheduler #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  gap_len,
  input  logic [CNT_W-1:0]  total_len,
  output logic [NUM_CH-1:0] enable,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_reg;
  logic [DIV_W-1:0]  div_cfg_reg, div_cnt_reg;
  logic [CNT_W-1:0]  burst_cfg_reg, gap_cfg_reg, total_cfg_reg;
  logic [CNT_W-1:0]  burst_cnt_reg, gap_cnt_reg, sample_cnt_reg;
  logic [CH_W-1:0]   ch_reg, en_ch_reg, sample_ch_reg;
  logic [NUM_CH-1:0] enable_reg;
  logic              sample_valid_reg, done_reg, aborted_reg;

  logic              is_idle, is_run, launch, tick, fire, final_fire, abort, burst_end;
  logic [DIV_W-1:0]  div_eff;
  logic [CNT_W-1:0]  burst_raw, burst_eff, gap_eff, total_eff;
  logic [CNT_W-1:0]  cnt_base, cnt_inc, bcnt_inc;
  logic [CH_W-1:0]   ch_base, ch_next;
  logic [NUM_CH-1:0] ch_onehot;

  // In IDLE the launching enable is computed straight from the config inputs,
  // so the first enable appears the cycle after start.
  assign is_idle    = (state_reg == S_IDLE);
  assign is_run     = (state_reg == S_BURST) || (state_reg == S_GAP);
  assign launch     = is_idle && start && !stop;
  assign div_eff    = is_idle ? div : div_cfg_reg;
  assign burst_raw  = is_idle ? burst_len : burst_cfg_reg;
  assign burst_eff  = (burst_raw == '0) ? CNT_W'(1) : burst_raw;
  assign gap_eff    = is_idle ? gap_len : gap_cfg_reg;
  assign total_eff  = is_idle ? total_len : total_cfg_reg;
  assign cnt_base   = is_idle ? '0 : sample_cnt_reg;
  assign ch_base    = is_idle ? '0 : ch_reg;
  assign cnt_inc    = cnt_base + CNT_W'(1);
  assign bcnt_inc   = (is_idle ? '0 : burst_cnt_reg) + CNT_W'(1);
  assign ch_next    = (ch_base == CH_W'(NUM_CH - 1)) ? '0 : ch_base + CH_W'(1);
  assign final_fire = (total_eff != '0) && (cnt_inc == total_eff);
  assign burst_end  = (bcnt_inc == burst_eff);
  assign tick       = (state_reg == S_BURST) && (div_cnt_reg == '0);
  // The final enable beats a simultaneous stop.
  assign fire       = launch || (tick && (!stop || final_fire));
  assign abort      = is_run && stop && !(tick && final_fire);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign ch_onehot[gi] = (ch_base == CH_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      div_cfg_reg      <= '0;
      div_cnt_reg      <= '0;
      burst_cfg_reg    <= CNT_W'(1);
      gap_cfg_reg      <= '0;
      total_cfg_reg    <= '0;
      burst_cnt_reg    <= '0;
      gap_cnt_reg      <= '0;
      sample_cnt_reg   <= '0;
      ch_reg           <= '0;
      en_ch_reg        <= '0;
      sample_ch_reg    <= '0;
      enable_reg       <= '0;
      sample_valid_reg <= 1'b0;
      done_reg         <= 1'b0;
      aborted_reg      <= 1'b0;
    end else begin
      if (launch) begin
        div_cfg_reg   <= div;
        burst_cfg_reg <= burst_eff;
        gap_cfg_reg   <= gap_len;
        total_cfg_reg <= total_len;
      end

      if (abort) begin
        state_reg <= S_IDLE;
      end else if (fire) begin
        // Saturate rather than wrap in unlimited mode.
        if (cnt_base != '1) sample_cnt_reg <= cnt_inc;
        ch_reg      <= ch_next;
        div_cnt_reg <= div_eff;
        if (final_fire) begin
          state_reg <= S_DONE;
        end else if (burst_end) begin
          burst_cnt_reg <= '0;
          if (gap_eff == '0) begin
            state_reg <= S_BURST;
          end else begin
            state_reg   <= S_GAP;
            gap_cnt_reg <= gap_eff - CNT_W'(1);
          end
        end else begin
          burst_cnt_reg <= bcnt_inc;
          state_reg     <= S_BURST;
        end
      end else begin
        case (state_reg)
          S_BURST: div_cnt_reg <= div_cnt_reg - DIV_W'(1);
          S_GAP: begin
            if (gap_cnt_reg == '0) begin
              state_reg     <= S_BURST;
              div_cnt_reg   <= '0;
              burst_cnt_reg <= '0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - CNT_W'(1);
            end
          end
          S_DONE:  state_reg <= S_IDLE;
          default: state_reg <= S_IDLE;
        endcase
      end

      enable_reg       <= fire ? ch_onehot : '0;
      en_ch_reg        <= fire ? ch_base : '0;
      sample_valid_reg <= |enable_reg;
      sample_ch_reg    <= en_ch_reg;
      done_reg         <= (state_reg == S_DONE);
      aborted_reg      <= abort;
    end
  end

  assign enable       = enable_reg;
  assign sample_valid = sample_valid_reg;
  assign sample_ch    = sample_ch_reg;
  assign busy         = is_run;
  assign done         = done_reg;
  assign aborted      = aborted_reg;
  assign sample_cnt   = sample_cnt_reg;

endmodule

// File: tb/tb_read_enable_scheduler.sv
// Directed bench: each vector runs 32 cycles from a start pulse and compares
// per-cycle bitmaps of the outputs against hand-computed expectations.
module tb_read_enable_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [7:0]  div;
  logic [15:0] burst_len, gap_len, total_len;
  logic [1:0]  enable;
  logic        sample_valid, busy, done, aborted;
  logic [0:0]  sample_ch;
  logic [15:0] sample_cnt;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  read_enable_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div),
    .burst_len(burst_len), .gap_len(gap_len), .total_len(total_len),
    .enable(enable), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .busy(busy), .done(done), .aborted(aborted), .sample_cnt(sample_cnt)
  );

  typedef struct {
    logic [7:0]  div;
    logic [15:0] burst, gap, total;
    int          stop_cyc;
    int          start_hold;
    bit          mut;
    logic [31:0] en_m, ch1_m, sv_m, done_m, abort_m, busy_m;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, want);
    end else begin
      $display("ok   %s vec=%0d value=%h", name, idx, got);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] en_a, ch_a, sv_a, sch_a, dn_a, ab_a, bz_a;
    logic        onehot_err;
    en_a = '0; ch_a = '0; sv_a = '0; sch_a = '0; dn_a = '0; ab_a = '0; bz_a = '0;
    onehot_err = 1'b0;
    for (int c = 0; c < 32; c++) begin
      start = (c < v.start_hold);
      stop  = (c == v.stop_cyc);
      if (c == 0) begin
        div = v.div; burst_len = v.burst; gap_len = v.gap; total_len = v.total;
      end else if (v.mut && c >= 2) begin
        div = 8'd3; burst_len = 16'd1; gap_len = 16'd7; total_len = 16'd2;
      end
      @(negedge clk);
      en_a[c]  = |enable;
      ch_a[c]  = enable[1];
      sv_a[c]  = sample_valid;
      sch_a[c] = sample_valid && (sample_ch == 1'b1);
      dn_a[c]  = done;
      ab_a[c]  = aborted;
      bz_a[c]  = busy;
      if (enable == 2'b11) onehot_err = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    chk("enable_cycles", idx, en_a, v.en_m);
    chk("enable_ch1", idx, ch_a, v.ch1_m);
    chk("sample_valid", idx, sv_a, v.sv_m);
    chk("sample_ch", idx, sch_a, v.ch1_m << 1);
    chk("done", idx, dn_a, v.done_m);
    chk("aborted", idx, ab_a, v.abort_m);
    chk("busy", idx, bz_a, v.busy_m);
    chk("sample_cnt", idx, 32'(sample_cnt), 32'(v.cnt));
    chk("onehot", idx, 32'(onehot_err), 32'd0);
  endtask

  initial begin
    logic any_pulse;
    // 4-enable bursts, no gap, 6 total
    vecs[0] = '{div:8'd0, burst:16'd4, gap:16'd0, total:16'd6, stop_cyc:-1, start_hold:1, mut:1'b0,
                en_m:32'h7E, ch1_m:32'h54, sv_m:32'hFC, done_m:32'h80, abort_m:32'h0, busy_m:32'h3E, cnt:16'd6};
    // divided rate with a 3-cycle gap
    vecs[1] = '{div:8'd2, burst:16'd2, gap:16'd3, total:16'd4, stop_cyc:-1, start_hold:1, mut:1'b0,
                en_m:32'h912, ch1_m:32'h810, sv_m:32'h1224, done_m:32'h1000, abort_m:32'h0, busy_m:32'h7FE, cnt:16'd4};
    // unlimited, stopped in cycle 9
    vecs[2] = '{div:8'd0, burst:16'd3, gap:16'd0, total:16'd0, stop_cyc:9, start_hold:1, mut:1'b0,
                en_m:32'h3FE, ch1_m:32'h154, sv_m:32'h7FC, done_m:32'h0, abort_m:32'h400, busy_m:32'h3FE, cnt:16'd9};
    // burst_len 0 acts as 1; restart begins on channel 0
    vecs[3] = '{div:8'd0, burst:16'd0, gap:16'd1, total:16'd3, stop_cyc:-1, start_hold:1, mut:1'b0,
                en_m:32'h2A, ch1_m:32'h8, sv_m:32'h54, done_m:32'h40, abort_m:32'h0, busy_m:32'h1E, cnt:16'd3};
    // stop coincides with the final enable
    vecs[4] = '{div:8'd0, burst:16'd4, gap:16'd0, total:16'd3, stop_cyc:2, start_hold:1, mut:1'b0,
                en_m:32'hE, ch1_m:32'h4, sv_m:32'h1C, done_m:32'h10, abort_m:32'h0, busy_m:32'h6, cnt:16'd3};
    // stop during GAP
    vecs[5] = '{div:8'd1, burst:16'd1, gap:16'd4, total:16'd0, stop_cyc:3, start_hold:1, mut:1'b0,
                en_m:32'h2, ch1_m:32'h0, sv_m:32'h4, done_m:32'h0, abort_m:32'h10, busy_m:32'hE, cnt:16'd1};
    // total of 1 completes on the launching enable
    vecs[6] = '{div:8'd1, burst:16'd1, gap:16'd5, total:16'd1, stop_cyc:-1, start_hold:1, mut:1'b0,
                en_m:32'h2, ch1_m:32'h0, sv_m:32'h4, done_m:32'h4, abort_m:32'h0, busy_m:32'h0, cnt:16'd1};
    // start and stop together in IDLE: nothing happens, count holds
    vecs[7] = '{div:8'd0, burst:16'd4, gap:16'd0, total:16'd6, stop_cyc:0, start_hold:1, mut:1'b0,
                en_m:32'h0, ch1_m:32'h0, sv_m:32'h0, done_m:32'h0, abort_m:32'h0, busy_m:32'h0, cnt:16'd1};
    // start held and config changed mid-run: same timing as vecs[0]
    vecs[8] = '{div:8'd0, burst:16'd4, gap:16'd0, total:16'd6, stop_cyc:-1, start_hold:5, mut:1'b1,
                en_m:32'h7E, ch1_m:32'h54, sv_m:32'hFC, done_m:32'h80, abort_m:32'h0, busy_m:32'h3E, cnt:16'd6};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    div = '0; burst_len = '0; gap_len = '0; total_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_enable", -1, 32'(enable), 32'd0);
    chk("rst_valid", -1, 32'(sample_valid), 32'd0);
    chk("rst_ch", -1, 32'(sample_ch), 32'd0);
    chk("rst_flags", -1, {29'd0, busy, done, aborted}, 32'd0);
    chk("rst_cnt", -1, 32'(sample_cnt), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a gap, then a fresh run.
    div = 8'd0; burst_len = 16'd1; gap_len = 16'd5; total_len = 16'd0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("gaprst_enable", -1, 32'(enable), 32'd0);
    chk("gaprst_busy", -1, 32'(busy), 32'd0);
    chk("gaprst_valid", -1, 32'(sample_valid), 32'd0);
    chk("gaprst_cnt", -1, 32'(sample_cnt), 32'd0);
    any_pulse = done | aborted;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      any_pulse = any_pulse | done | aborted | busy;
    end
    chk("gaprst_quiet", -1, 32'(any_pulse), 32'd0);
    @(posedge clk); #1;
    run_vec(9, vecs[0]);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
